// File: rtl/dot_product_pkg.sv
// Shared definitions for the dot-product compute stage: FSM encoding and
// accumulator width derivation.
package dot_product_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Wide enough for Ram_Depth full-scale products plus one guard bit.
    function automatic int calc_acc_width(input int dw, input int aw);
        return 2 * dw + aw + 1;
    endfunction

endpackage

// File: rtl/dot_product_ctrl_mac_unit.sv
// Registered multiply-accumulate: clear has priority over valid_in; prod is
// the zero-extended product of the current operands.
module mac_unit
    import dot_product_pkg::*;
#(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int acc_width  = calc_acc_width(data_width, addr_width)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  valid_in,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic [acc_width-1:0]  acc,
    output logic [acc_width-1:0]  prod
);

    localparam int PW = 2 * data_width;

    logic [PW-1:0]        prod_raw;
    logic [acc_width-1:0] acc_d, acc_q;

    always_comb begin
        prod_raw = a * b;
        prod     = {{(acc_width - PW){1'b0}}, prod_raw};
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (valid_in) begin
            acc_d = acc_q + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/dot_product_ctrl.sv
// Sweeps a shared read address over two 1-cycle-latency SRAMs, accumulates
// the element products and reports the dot product with a Done pulse.
module dot_product_ctrl
    import dot_product_pkg::*;
#(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int Ram_Depth  = 1 << addr_width,
    parameter int acc_width  = calc_acc_width(data_width, addr_width)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [addr_width:0]   Length,
    output logic                  Chip_Select,
    output logic                  En_Read,
    output logic [addr_width-1:0] Read_Addr,
    input  logic [data_width-1:0] A_Data,
    input  logic [data_width-1:0] B_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic [acc_width-1:0]  Result,
    output logic [1:0]            state_dbg
);

    localparam int LW = addr_width + 1;

    logic [1:0]            state_d, state_q;
    logic [addr_width-1:0] addr_d, addr_q;
    logic [LW-1:0]         len_d, len_q;
    logic                  en_read_d, en_read_q;
    logic                  cs_d, cs_q;
    logic                  busy_d, busy_q;
    logic                  done_d, done_q;
    logic [acc_width-1:0]  result_d, result_q;
    logic                  d_valid_q;
    logic                  mac_clear;
    logic [acc_width-1:0]  acc, prod;
    logic [LW-1:0]         last_addr;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        en_read_d = en_read_q;
        cs_d      = cs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        result_d  = result_q;
        mac_clear = 1'b0;
        last_addr = len_q - LW'(1);

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    busy_d = 1'b1;
                    cs_d   = 1'b1;
                    if (Length == '0) begin
                        result_d = '0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        // Clamp matters only when Length can exceed the depth.
                        len_d     = (Length > LW'(Ram_Depth)) ? LW'(Ram_Depth) : Length;
                        mac_clear = 1'b1;
                        addr_d    = '0;
                        en_read_d = 1'b1;
                        state_d   = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if ({1'b0, addr_q} == last_addr) begin
                    en_read_d = 1'b0;
                    addr_d    = '0;
                    state_d   = ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The final element is on the bus now and not yet in acc.
                result_d = acc + prod;
                done_d   = 1'b1;
                state_d  = ST_DONE;
            end
            default: begin
                busy_d  = 1'b0;
                cs_d    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            en_read_q <= 1'b0;
            cs_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            en_read_q <= en_read_d;
            cs_q      <= cs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            d_valid_q <= en_read_q;
        end
    end

    mac_unit #(
        .data_width(data_width),
        .addr_width(addr_width),
        .acc_width (acc_width)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear   (mac_clear),
        .valid_in(d_valid_q),
        .a       (A_Data),
        .b       (B_Data),
        .acc     (acc),
        .prod    (prod)
    );

    assign Chip_Select = cs_q;
    assign En_Read     = en_read_q;
    assign Read_Addr   = addr_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Result      = result_q;
    assign state_dbg   = state_q;

endmodule
